serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
Bit-serial multi-bit adder controller that time-shares a single 1-bit full-adder cell across WIDTH cycles.
- Accepts a start pulse with two WIDTH-bit operands and a carry-in.
- Feeds operand bits LSB-first through the cell, one bit per clock, and registers the carry between cycles.
- Presents the WIDTH-bit sum and carry-out with a one-cycle done strobe.
- Serves as the area-minimal adder option beside the parallel full-adder variants in the arithmetic practice datapath.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  operand A; sampled on the accepting edge.
b  input  WIDTH  operand B; sampled on the accepting edge.
ci  input  1  carry-in; sampled on the accepting edge.
busy  output  1  high while state is RUN.
done  output  1  one-cycle strobe; result valid.
s  output  WIDTH  registered sum.
co  output  1  registered carry-out.

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset: state=IDLE; busy=0, done=0, s=0, co=0; shift registers, carry register and bit counter all cleared.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - load A_sh<=a, B_sh<=b, c_reg<=ci, cnt<=0.
  - next state RUN.
- IDLE, start=0: stay in IDLE; all outputs hold.
- RUN, each edge Ek (k=1..WIDTH):
  - The full-adder cell sees A_sh[0], B_sh[0], c_reg.
  - Cell sum bit shifts into S_sh from the MSB side (right shift).
  - A_sh and B_sh shift right by 1.
  - c_reg <= cell carry-out; cnt++.
- RUN exit: on edge E_WIDTH (cnt==WIDTH-1 before the edge):
  - s <= final S_sh value including this cycle's bit.
  - co <= cell carry-out.
  - next state DONE.
- DONE: done=1 for exactly one cycle, then unconditional return to IDLE.
- Latency: done is high during the cycle that starts at edge E_WIDTH, i.e. WIDTH edges after the start-accepting edge.
- Throughput: one operation per WIDTH+2 cycles.
- Output stability:
  - s and co change only on the RUN→DONE edge (and on reset).
  - They hold the last result indefinitely, including through the next operation until its completion.
- busy = (state==RUN), registered or state-decoded, glitch-free. done = (state==DONE).
- start while in RUN or DONE: ignored, not queued. A start held high continuously re-triggers only once IDLE is reached.
- Operand changes on a/b/ci after acceptance: no effect on the in-flight result.
- rst asserted mid-RUN: next edge forces the full reset values, and the partial result is discarded. start asserted on the same edge as rst is ignored.
- WIDTH=1: RUN lasts one edge; the result is identical to a single full add.
- Arithmetic: {co,s} = a + b + ci, modulo 2^(WIDTH+1).
- Counter width: enough to hold WIDTH-1.

Decomposition:
- Shared package/header holds:
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - the default WIDTH constant.
- One sub-module: instantiate the existing fa_dataflow cell (ports s, co, a, b, ci) as the single bit-slice.
- Shift registers, counter and FSM stay inline.

Test Plan:
1. WIDTH=8, rst 2 cycles, then idle 3 cycles -> busy=0, done=0, s=8'h00, co=0 throughout.
2. a=8'h5A, b=8'h3C, ci=0, start 1 cycle -> busy high 8 cycles; done high on the 8th edge after acceptance; s=8'h96, co=0.
3. a=8'hFF, b=8'h01, ci=0 -> s=8'h00, co=1. Then a=8'hFF, b=8'hFF, ci=1 -> s=8'hFF, co=1. Between completions s holds 8'h00.
4. Accept a=8'h12, b=8'h34. Then change to a=8'hFF, b=8'hFF and keep start high during RUN/DONE -> result s=8'h46, co=0. A second operation then starts on the first IDLE cycle, using the a/b present then.
5. rst asserted at RUN cycle 4 of a=8'hAA, b=8'h55 -> next edge: state IDLE, busy=0, done never pulses, s/co=0. A fresh start with a=8'h01, b=8'h01 -> s=8'h02.
6. Random sweep, 200 operations, WIDTH=8 and WIDTH=1 builds -> every {co,s} equals a+b+ci. done count equals accepted-start count; exactly WIDTH busy cycles per operation.

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder controller: state encoding,
// default operand width and the bit-counter sizing helper.
package serial_adder_ctrl_pkg;

   localparam int WIDTH_DEFAULT = 8;
   localparam int WIDTH_MIN     = 1;
   localparam int WIDTH_MAX     = 32;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      DONE = 2'b10
   } state_e;

   // Counter must hold WIDTH-1; a 1-bit operand still needs a 1-bit counter.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// Single-bit full-adder cell, written as pure dataflow. The serial adder
// time-shares one instance of this cell across all operand bits.
module fa_dataflow (
   output logic s,
   output logic co,
   input  logic a,
   input  logic b,
   input  logic ci
);

   logic p;

   assign p  = a ^ b;
   assign s  = p ^ ci;
   assign co = (a & b) | (ci & p);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder controller. Operands are captured on the
// accepting edge, then fed LSB-first through one full-adder cell, one bit per
// clock, with the carry held in a register between cycles. The WIDTH-bit sum
// and carry-out are registered on the last RUN edge and held until the next
// operation completes; done pulses for one cycle when they update.
module serial_adder_ctrl
   import serial_adder_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             co
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("serial_adder_ctrl: WIDTH must be in 1..32");
   end

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sh_q,  a_sh_d;
   logic [WIDTH-1:0]   b_sh_q,  b_sh_d;
   logic [WIDTH-1:0]   s_sh_q,  s_sh_d;
   logic               c_q,     c_d;
   logic [CNT_W-1:0]   cnt_q,   cnt_d;
   logic [WIDTH-1:0]   s_q,     s_d;
   logic               co_q,    co_d;

   logic               fa_s;
   logic               fa_co;
   logic               last_bit;

   // The one shared bit-slice: always looks at the current LSBs and carry.
   fa_dataflow u_fa (
      .s  (fa_s),
      .co (fa_co),
      .a  (a_sh_q[0]),
      .b  (b_sh_q[0]),
      .ci (c_q)
   );

   assign last_bit = (cnt_q == CNT_LAST);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state decode: start only matters in IDLE; DONE always returns.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)    state_d = RUN;
         RUN:     if (last_bit) state_d = DONE;
         DONE:                  state_d = IDLE;
         default:               state_d = IDLE;
      endcase
   end

   // Datapath next-values: load on accept, shift one bit per RUN cycle,
   // commit the result on the last RUN cycle only.
   always_comb begin
      a_sh_d = a_sh_q;
      b_sh_d = b_sh_q;
      s_sh_d = s_sh_q;
      c_d    = c_q;
      cnt_d  = cnt_q;
      s_d    = s_q;
      co_d   = co_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               a_sh_d = a;
               b_sh_d = b;
               c_d    = ci;
               cnt_d  = '0;
            end
         end
         RUN: begin
            a_sh_d = a_sh_q >> 1;
            b_sh_d = b_sh_q >> 1;
            // Sum bits enter at the MSB so that after WIDTH shifts the
            // first (LSB) bit has arrived at bit 0; works for WIDTH=1 too.
            s_sh_d            = s_sh_q >> 1;
            s_sh_d[WIDTH-1]   = fa_s;
            c_d               = fa_co;
            cnt_d             = cnt_q + CNT_ONE;
            if (last_bit) begin
               s_d  = s_sh_d;
               co_d = fa_co;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers with synchronous reset; an aborted run is discarded.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_q <= '0;
         b_sh_q <= '0;
         s_sh_q <= '0;
         c_q    <= 1'b0;
         cnt_q  <= '0;
         s_q    <= '0;
         co_q   <= 1'b0;
      end else begin
         a_sh_q <= a_sh_d;
         b_sh_q <= b_sh_d;
         s_sh_q <= s_sh_d;
         c_q    <= c_d;
         cnt_q  <= cnt_d;
         s_q    <= s_d;
         co_q   <= co_d;
      end
   end

   // Outputs: status decoded straight from the state register, result held.
   always_comb begin
      busy = (state_q == RUN);
      done = (state_q == DONE);
      s    = s_q;
      co   = co_q;
   end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit and a 1-bit instance
// run side by side against a transaction-level model of the adder.
module tb_serial_adder_ctrl;

   localparam int W8 = 8;
   localparam int W1 = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8, start8, ci8, busy8, done8, co8;
   logic [7:0] a8, b8, s8;
   logic       rst1, start1, ci1, busy1, done1, co1;
   logic [0:0] a1, b1, s1;

   serial_adder_ctrl #(.WIDTH(W8)) dut8 (
      .clk(clk), .rst(rst8), .start(start8), .a(a8), .b(b8), .ci(ci8),
      .busy(busy8), .done(done8), .s(s8), .co(co8)
   );

   serial_adder_ctrl #(.WIDTH(W1)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .a(a1), .b(b1), .ci(ci1),
      .busy(busy1), .done(done1), .s(s1), .co(co1)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Transaction-level model: an accepted request produces a+b+ci, visible
   // WIDTH edges later for one done cycle, busy for the WIDTH cycles between.
   int          m_w     [2] = '{8, 1};
   int          m_phase [2];
   logic [32:0] m_pend  [2];
   logic [32:0] m_res   [2];
   int          m_acc   [2];
   bit          m_valid [2];
   int          dut_done_cnt [2];

   task automatic model_step(input int i, input logic r, input logic st,
                             input logic [31:0] av, input logic [31:0] bv, input logic c);
      if (r) begin
         m_phase[i] = 0;
         m_res[i]   = '0;
         m_valid[i] = 1'b1;
      end else if (m_phase[i] == 0) begin
         if (st) begin
            m_pend[i]  = {1'b0, av} + {1'b0, bv} + 33'(c);
            m_phase[i] = 1;
            m_acc[i]++;
         end
      end else if (m_phase[i] == m_w[i]) begin
         m_res[i]   = m_pend[i];
         m_phase[i] = m_w[i] + 1;
      end else if (m_phase[i] < m_w[i]) begin
         m_phase[i]++;
      end else begin
         m_phase[i] = 0;
      end
   endtask

   always @(posedge clk) begin
      model_step(0, rst8, start8, 32'(a8), 32'(b8), ci8);
      model_step(1, rst1, start1, 32'(a1), 32'(b1), ci1);
   end

   // Cycle-by-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid[0]) begin
         chk("busy8", 64'(busy8), 64'(m_phase[0] >= 1 && m_phase[0] <= W8));
         chk("done8", 64'(done8), 64'(m_phase[0] == W8 + 1));
         chk("s8",    64'(s8),    64'(m_res[0][7:0]));
         chk("co8",   64'(co8),   64'(m_res[0][8]));
         if (done8) dut_done_cnt[0]++;
      end
      if (m_valid[1]) begin
         chk("busy1", 64'(busy1), 64'(m_phase[1] >= 1 && m_phase[1] <= W1));
         chk("done1", 64'(done1), 64'(m_phase[1] == W1 + 1));
         chk("s1",    64'(s1),    64'(m_res[1][0]));
         chk("co1",   64'(co1),   64'(m_res[1][1]));
         if (done1) dut_done_cnt[1]++;
      end
   end

   // mode 0: drop start after acceptance; 1: random junk on inputs while
   // running; 2: leave start untouched. Returns busy cycles and negedges seen.
   task automatic wait_done8(input int mode, output int busy_cycles, output int edges);
      bit got;
      got = 1'b0;
      busy_cycles = 0;
      edges = 0;
      for (int k = 0; k < 64 && !got; k++) begin
         @(negedge clk);
         edges++;
         if (done8) begin
            got = 1'b1;
            if (mode != 2) start8 = 1'b0;
         end else begin
            if (busy8) busy_cycles++;
            if (mode == 0) start8 = 1'b0;
            if (mode == 1) begin
               a8 = 8'($urandom); b8 = 8'($urandom);
               ci8 = 1'($urandom); start8 = 1'($urandom);
            end
         end
      end
      chk("done8_seen", 64'(got), 64'd1);
   endtask

   task automatic wait_done1(output int busy_cycles, output int edges);
      bit got;
      got = 1'b0;
      busy_cycles = 0;
      edges = 0;
      for (int k = 0; k < 16 && !got; k++) begin
         @(negedge clk);
         edges++;
         if (done1) begin
            got = 1'b1;
            start1 = 1'b0;
         end else begin
            if (busy1) busy_cycles++;
            a1 = 1'($urandom); b1 = 1'($urandom);
            ci1 = 1'($urandom); start1 = 1'($urandom);
         end
      end
      chk("done1_seen", 64'(got), 64'd1);
   endtask

   task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic c, input int mode,
                      output int busy_cycles, output int edges);
      @(negedge clk);
      a8 = av; b8 = bv; ci8 = c; start8 = 1'b1;
      wait_done8(mode, busy_cycles, edges);
   endtask

   int n_done8 = 0;

   initial begin
      #1_000_000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      rst8 = 1'b1; start8 = 1'b0; a8 = '0; b8 = '0; ci8 = 1'b0;
      rst1 = 1'b1; start1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0;
      fork
         begin : p8
            int bc, ed;
            logic [7:0] av, bv;
            logic       cv;
            repeat (2) @(negedge clk);
            rst8 = 1'b0;
            // idle after reset
            repeat (3) begin
               @(negedge clk);
               chk("idle_after_reset", 64'({busy8, done8, co8, s8}), 64'd0);
            end
            // basic add, latency and busy length
            op8(8'h5A, 8'h3C, 1'b0, 0, bc, ed);
            n_done8++;
            chk("add_5A_3C", 64'({co8, s8}), 64'h096);
            chk("model_pin_5A_3C", 64'(m_res[0][8:0]), 64'h096);
            chk("busy_cycles_5A", 64'(bc), 64'd8);
            chk("latency_edges_5A", 64'(ed - 1), 64'd8);
            // carry propagation
            op8(8'hFF, 8'h01, 1'b0, 0, bc, ed);
            n_done8++;
            chk("add_FF_01", 64'({co8, s8}), 64'h100);
            chk("model_pin_FF_01", 64'(m_res[0][8:0]), 64'h100);
            @(negedge clk);
            a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            chk("hold_s_midrun", 64'({co8, s8}), 64'h100);
            wait_done8(0, bc, ed);
            n_done8++;
            chk("add_FF_FF_1", 64'({co8, s8}), 64'h1FF);
            // operand change after acceptance, start held through RUN/DONE
            @(negedge clk);
            a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0; start8 = 1'b1;
            @(negedge clk);
            a8 = 8'hFF; b8 = 8'hFF;
            wait_done8(2, bc, ed);
            n_done8++;
            chk("add_12_34_isolated", 64'({co8, s8}), 64'h046);
            @(negedge clk);
            chk("start_ignored_in_done", 64'(busy8), 64'd0);
            @(negedge clk);
            chk("retrigger_in_idle", 64'(busy8), 64'd1);
            start8 = 1'b0;
            wait_done8(0, bc, ed);
            n_done8++;
            chk("add_retrigger_FF_FF", 64'({co8, s8}), 64'h1FE);
            // reset mid-RUN with a simultaneous start
            @(negedge clk);
            a8 = 8'hAA; b8 = 8'h55; ci8 = 1'b0; start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
            repeat (3) @(negedge clk);
            rst8 = 1'b1; start8 = 1'b1;
            @(negedge clk);
            chk("abort_state", 64'({busy8, done8, co8, s8}), 64'd0);
            rst8 = 1'b0; start8 = 1'b0;
            repeat (12) begin
               @(negedge clk);
               chk("abort_no_done", 64'(done8), 64'd0);
            end
            op8(8'h01, 8'h01, 1'b0, 0, bc, ed);
            n_done8++;
            chk("add_after_abort", 64'({co8, s8}), 64'h002);
            // random sweep
            for (int n = 0; n < 200; n++) begin
               av = 8'($urandom); bv = 8'($urandom); cv = 1'($urandom);
               op8(av, bv, cv, 1, bc, ed);
               n_done8++;
               chk("rand8_sum", 64'({co8, s8}), 64'(9'(av) + 9'(bv) + 9'(cv)));
               chk("rand8_busy", 64'(bc), 64'd8);
               chk("rand8_latency", 64'(ed - 1), 64'd8);
            end
            @(negedge clk);
         end
         begin : p1
            int bc, ed;
            logic av, bv, cv;
            repeat (2) @(negedge clk);
            rst1 = 1'b0;
            @(negedge clk);
            chk("idle1_after_reset", 64'({busy1, done1, co1, s1}), 64'd0);
            for (int n = 0; n < 200; n++) begin
               @(negedge clk);
               av = 1'($urandom); bv = 1'($urandom); cv = 1'($urandom);
               a1 = av; b1 = bv; ci1 = cv; start1 = 1'b1;
               wait_done1(bc, ed);
               chk("rand1_sum", 64'({co1, s1}), 64'(2'(av) + 2'(bv) + 2'(cv)));
               chk("rand1_busy", 64'(bc), 64'd1);
               chk("rand1_latency", 64'(ed - 1), 64'd1);
            end
            @(negedge clk);
         end
      join
      chk("done_count8", 64'(dut_done_cnt[0]), 64'(n_done8));
      chk("done_count1", 64'(dut_done_cnt[1]), 64'd200);
      chk("accept_count1", 64'(m_acc[1]), 64'd200);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
